// File: rtl/pic_sched_if.sv
// Stream/match bus for pic_sched: two sorted sparse-index input streams (A, B)
// and the matched-position output stream (M).
interface pic_sched_if #(
  parameter int IDX_W = 16,
  parameter int POS_W = 16
);
  logic [IDX_W-1:0]   a_idx;
  logic               a_valid;
  logic               a_last;
  logic               a_ready;
  logic [IDX_W-1:0]   b_idx;
  logic               b_valid;
  logic               b_last;
  logic               b_ready;
  logic [2*POS_W-1:0] m_data;
  logic               m_valid;
  logic               m_ready;

  modport master (
    output a_idx, a_valid, a_last, b_idx, b_valid, b_last, m_ready,
    input  a_ready, b_ready, m_data, m_valid
  );

  modport slave (
    input  a_idx, a_valid, a_last, b_idx, b_valid, b_last, m_ready,
    output a_ready, b_ready, m_data, m_valid
  );
endinterface

// File: rtl/pic_sched.sv
// Sparse-index intersection scheduler: merges sorted A/B streams and queues matching
// position pairs in a FWFT FIFO. Optional PIC_SCHED_STATS_EN adds the match_cnt output.
module pic_sched #(
  parameter int IDX_W = 16,
  parameter int POS_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  pic_sched_if.slave       bus,
  output logic             busy,
`ifdef PIC_SCHED_STATS_EN
  output logic [POS_W-1:0] match_cnt,
`endif
  output logic             done
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH_A, S_FLUSH_B, S_DRAIN} state_t;

  state_t             r_state, w_next;
  logic [POS_W-1:0]   r_a_pos, r_b_pos;
  logic [2*POS_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [AW:0]        r_count;
  logic               w_pop_a, w_pop_b, w_push, w_fpop, w_full, w_start;
  logic [IDX_W-1:0]   w_a_idx, w_b_idx;

  assign w_a_idx = bus.a_idx;
  assign w_b_idx = bus.b_idx;
  assign w_full  = (r_count == FULL);
  assign w_start = (r_state == S_IDLE) && start;
  assign w_fpop  = bus.m_valid && bus.m_ready;

  always_comb begin
    w_next  = r_state;
    w_pop_a = 1'b0;
    w_pop_b = 1'b0;
    w_push  = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        if (bus.a_valid && bus.b_valid) begin
          if (w_a_idx < w_b_idx) begin
            w_pop_a = 1'b1;
          end else if (w_b_idx < w_a_idx) begin
            w_pop_b = 1'b1;
          end else if (!w_full) begin
            w_push  = 1'b1;
            w_pop_a = 1'b1;
            w_pop_b = 1'b1;
          end
          // Whichever stream has just delivered its last element leaves the other to flush
          if (w_pop_a && bus.a_last && w_pop_b && bus.b_last) w_next = S_DRAIN;
          else if (w_pop_a && bus.a_last)                     w_next = S_FLUSH_B;
          else if (w_pop_b && bus.b_last)                     w_next = S_FLUSH_A;
        end
      end
      S_FLUSH_A: begin
        w_pop_a = bus.a_valid;
        if (bus.a_valid && bus.a_last) w_next = S_DRAIN;
      end
      S_FLUSH_B: begin
        w_pop_b = bus.b_valid;
        if (bus.b_valid && bus.b_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_count == '0) begin
          done   = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.a_ready = w_pop_a;
  assign bus.b_ready = w_pop_b;
  assign bus.m_valid = (r_count != '0);
  assign bus.m_data  = r_mem[r_rptr];
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_pos <= '0;
      r_b_pos <= '0;
    end else if (w_start) begin
      r_a_pos <= '0;
      r_b_pos <= '0;
    end else if (r_state == S_RUN) begin
      if (w_pop_a) r_a_pos <= r_a_pos + POS_W'(1);
      if (w_pop_b) r_b_pos <= r_b_pos + POS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {r_a_pos, r_b_pos};
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_fpop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_fpop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef PIC_SCHED_STATS_EN
  logic [POS_W-1:0] r_match_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_match_cnt <= '0;
    else if (w_start)                      r_match_cnt <= '0;
    else if (w_push && r_match_cnt != '1)  r_match_cnt <= r_match_cnt + POS_W'(1);
  end

  assign match_cnt = r_match_cnt;
`endif
endmodule

// File: tb/tb_pic_sched.sv
// Self-checking bench for pic_sched: directed scenarios plus randomized sorted streams
// checked against a set-intersection reference model.
module tb_pic_sched;
  localparam int IDX_W = 16;
  localparam int POS_W = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
`ifdef PIC_SCHED_STATS_EN
  logic [POS_W-1:0] match_cnt;
`endif

  pic_sched_if #(.IDX_W(IDX_W), .POS_W(POS_W)) bus ();

  pic_sched #(.IDX_W(IDX_W), .POS_W(POS_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
`ifdef PIC_SCHED_STATS_EN
    .match_cnt (match_cnt),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [IDX_W-1:0]   a_q[$];
  logic [IDX_W-1:0]   b_q[$];
  logic [2*POS_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every (i,j) with A[i]==B[j], ordered by position in A
  task automatic build_exp();
    exp_q.delete();
    foreach (a_q[i])
      foreach (b_q[j])
        if (a_q[i] == b_q[j]) exp_q.push_back({POS_W'(i), POS_W'(j)});
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_last = 1'b0; bus.a_idx = '0;
    bus.b_valid = 1'b0; bus.b_last = 1'b0; bus.b_idx = '0;
    bus.m_ready = 1'b0;
  endtask

  task automatic run_case(input string name, input bit rnd, input int hold);
    int ai = 0, bi = 0, ndone = 0, cyc = 0, npairs;
    bit fin = 1'b0;
    build_exp();
    npairs = exp_q.size();
    @(negedge clk);
    idle_inputs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({name, ":busy_after_start"}, busy, 1);
`ifdef PIC_SCHED_STATS_EN
    chk({name, ":match_cnt_cleared"}, match_cnt, 0);
`endif
    while (!fin && cyc < 600) begin
      bus.a_valid = (ai < a_q.size()) && (!rnd || $urandom_range(0, 3) != 0);
      bus.a_idx   = (ai < a_q.size()) ? a_q[ai] : '0;
      bus.a_last  = (ai == a_q.size() - 1);
      bus.b_valid = (bi < b_q.size()) && (!rnd || $urandom_range(0, 3) != 0);
      bus.b_idx   = (bi < b_q.size()) ? b_q[bi] : '0;
      bus.b_last  = (bi == b_q.size() - 1);
      bus.m_ready = (cyc >= hold) && (!rnd || $urandom_range(0, 1) != 0);
      #1;
      if (hold > 0 && cyc == hold - 1) begin
        chk({name, ":stall_a_ready"}, bus.a_ready, 0);
        chk({name, ":stall_b_ready"}, bus.b_ready, 0);
        chk({name, ":stall_pops"}, ai, DEPTH);
        chk({name, ":stall_m_valid"}, bus.m_valid, 1);
      end
      if (!bus.a_valid) chk({name, ":a_ready_no_valid"}, bus.a_ready, 0);
      if (!bus.b_valid) chk({name, ":b_ready_no_valid"}, bus.b_ready, 0);
      if (bus.a_valid && bus.a_ready) ai++;
      if (bus.b_valid && bus.b_ready) bi++;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) chk({name, ":extra_pair"}, bus.m_valid, 0);
        else                   chk({name, ":m_data"}, bus.m_data, exp_q.pop_front());
      end
      if (done) begin
        ndone++;
        fin = 1'b1;
        chk({name, ":pairs_left_at_done"}, exp_q.size(), 0);
`ifdef PIC_SCHED_STATS_EN
        chk({name, ":match_cnt_at_done"}, match_cnt, npairs);
`endif
      end
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    chk({name, ":finished_in_budget"}, fin, 1);
    chk({name, ":done_count"}, ndone, 1);
    chk({name, ":a_consumed"}, ai, a_q.size());
    chk({name, ":b_consumed"}, bi, b_q.size());
    #1;
    chk({name, ":busy_after_done"}, busy, 0);
    chk({name, ":done_single_pulse"}, done, 0);
  endtask

  initial begin
    int ai;
    logic [IDX_W-1:0] v, base;
    idle_inputs();
    #12;
    chk("reset:busy", busy, 0);
    chk("reset:done", done, 0);
    chk("reset:m_valid", bus.m_valid, 0);
    chk("reset:m_data", bus.m_data, 0);
    chk("reset:a_ready", bus.a_ready, 0);
    chk("reset:b_ready", bus.b_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    a_q = '{1, 3, 5, 7}; b_q = '{3, 4, 7};
    run_case("basic", 1'b0, 0);
    a_q = '{2, 9}; b_q = '{2, 4, 6, 8};
    run_case("a_ends_first", 1'b0, 0);
    a_q = '{1, 3}; b_q = '{2, 4};
    run_case("disjoint", 1'b0, 0);
    a_q = '{0, 1, 2, 3, 4, 5, 6, 7}; b_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_case("fifo_full_stall", 1'b0, 20);
    a_q = '{1, 16'h8000}; b_q = '{16'h8000};
    run_case("unsigned_cmp", 1'b0, 0);
    a_q = '{4}; b_q = '{1, 2, 4, 9};
    run_case("single_a", 1'b0, 0);

    // Reset in RUN with two pairs queued
    a_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ai = 0;
    for (int k = 0; k < 20 && ai < 2; k++) begin
      bus.a_valid = 1'b1; bus.a_idx = a_q[ai]; bus.a_last = 1'b0;
      bus.b_valid = 1'b1; bus.b_idx = a_q[ai]; bus.b_last = 1'b0;
      bus.m_ready = 1'b0;
      #1;
      if (bus.a_ready) ai++;
      @(negedge clk);
    end
    #1;
    chk("rst_mid:queued_before", bus.m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid:m_valid", bus.m_valid, 0);
    chk("rst_mid:busy", busy, 0);
    chk("rst_mid:a_ready", bus.a_ready, 0);
    chk("rst_mid:b_ready", bus.b_ready, 0);
    chk("rst_mid:m_data", bus.m_data, 0);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("rst_mid:no_done", done, 0);
    end
    rst_n = 1'b1;
    a_q = '{5, 6}; b_q = '{6};
    run_case("after_reset", 1'b0, 0);

    for (int t = 0; t < 25; t++) begin
      a_q.delete(); b_q.delete();
      case ($urandom_range(0, 2))
        0:       base = '0;
        1:       base = 16'h7FF8;
        default: base = 16'hFF00;
      endcase
      v = base;
      for (int k = 0; k < 12; k++) begin
        v = v + IDX_W'($urandom_range(1, 3));
        case ($urandom_range(0, 3))
          0: a_q.push_back(v);
          1: b_q.push_back(v);
          2: begin a_q.push_back(v); b_q.push_back(v); end
          default: ;
        endcase
      end
      if (a_q.size() == 0) a_q.push_back(v + IDX_W'(1));
      if (b_q.size() == 0) b_q.push_back(v + IDX_W'(2));
      run_case($sformatf("rand%0d", t), 1'b1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
